// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcode/funct constants, field
// slices, forwarding-select encodings and the muldiv operation/state types.
// The muldiv-related items are only consumed when MULDIV_EN is defined.
package ex_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned MD_OP_W = 3;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Forward select encodings (11 falls back to the DE value)
  localparam logic [1:0] FWD_DE = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Payload of the E->M pipeline registers
  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] instruc;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] wra;
  } em_t;

  function automatic logic [5:0] instr_op(input logic [XLEN-1:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [RA_W-1:0] instr_rs(input logic [XLEN-1:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [RA_W-1:0] instr_rt(input logic [XLEN-1:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [XLEN-1:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO. Built only when MULDIV_EN
// is defined. A mult/div start in IDLE captures operands and runs for the
// configured cycle count; the result commits to HI/LO on the last busy cycle.
// mthi/mtlo write directly while IDLE; muldiv ops arriving while BUSY are ignored.
`ifdef MULDIV_EN
module ex_stage_muldiv_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  output logic [XLEN-1:0]    hi,
  output logic [XLEN-1:0]    lo,
  output logic               busy
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MD_OP_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic signed [2*XLEN-1:0] sext_a_c, sext_b_c;
  logic [2*XLEN-1:0]        prod_c;
  logic [XLEN-1:0]          divisor_c, quot_c, rem_c;
  logic                     div_zero_c, is_mult_c;

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == MD_BUSY);

  // Result datapath evaluated from the captured operands
  always_comb begin
    is_mult_c  = (op_q == MD_MULT) || (op_q == MD_MULTU);
    div_zero_c = (b_q == '0);
    divisor_c  = div_zero_c ? XLEN'(1) : b_q;
    sext_a_c   = {{XLEN{a_q[XLEN-1]}}, a_q};
    sext_b_c   = {{XLEN{b_q[XLEN-1]}}, b_q};
    if (op_q == MD_MULT) begin
      prod_c = sext_a_c * sext_b_c;
    end else begin
      prod_c = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
    end
    if (op_q == MD_DIV) begin
      quot_c = $signed(a_q) / $signed(divisor_c);
      rem_c  = $signed(a_q) % $signed(divisor_c);
    end else begin
      quot_c = a_q / divisor_c;
      rem_c  = a_q % divisor_c;
    end
  end

  // Next-state, counter and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = ((op == MD_MULT) || (op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                          : CNT_W'(DIV_CYCLES);
        end else if (op == MD_MTHI) begin
          hi_d = a;
        end else if (op == MD_MTLO) begin
          lo_d = a;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          if (is_mult_c) begin
            hi_d = prod_c[2*XLEN-1:XLEN];
            lo_d = prod_c[XLEN-1:0];
          end else if (!div_zero_c) begin
            hi_d = rem_c;
            lo_d = quot_c;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, E->M pipeline registers and the
// optional multiply/divide unit with HI/LO (enabled by defining MULDIV_EN).
// Without MULDIV_EN the muldiv instructions execute as nops and E_mdBusy is 0.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DE_RD1,
  input  logic [31:0] DE_RD2,
  input  logic [31:0] DE_instruc,
  input  logic [4:0]  DE_WRA,
  input  logic [31:0] DE_Ext,
  input  logic [31:0] DE_PC,
  input  logic [1:0]  E_FwdRS,
  input  logic [1:0]  E_FwdRT,
  input  logic [31:0] E_M_Pass,
  input  logic [31:0] E_W_Pass,
  output logic [4:0]  E_rs,
  output logic [4:0]  E_rt,
  output logic        E_mdBusy,
  output logic [31:0] EM_ALUOut,
  output logic [31:0] EM_RD2,
  output logic [31:0] EM_instruc,
  output logic [31:0] EM_PC,
  output logic [4:0]  EM_WRA
);

  // A zero cycle count would leave the muldiv FSM stuck in BUSY
  if (MULT_CYCLES == 0 || DIV_CYCLES == 0) begin : g_cycles_check
    $error("ex_stage: MULT_CYCLES and DIV_CYCLES must be nonzero");
  end

  logic [XLEN-1:0] a_c, b_c, alu_c;
  em_t             em_d, em_q;

`ifdef MULDIV_EN
  logic            md_start_c;
  md_op_e          md_op_c;
  logic [XLEN-1:0] md_hi, md_lo;
  logic            md_busy;

  ex_stage_muldiv_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_muldiv_unit (
    .clk  (clk),
    .reset(reset),
    .start(md_start_c),
    .op   (md_op_c),
    .a    (a_c),
    .b    (b_c),
    .hi   (md_hi),
    .lo   (md_lo),
    .busy (md_busy)
  );

  assign E_mdBusy = md_start_c | md_busy;
`else
  assign E_mdBusy = 1'b0;
`endif

  assign E_rs = instr_rs(DE_instruc);
  assign E_rt = instr_rt(DE_instruc);

  // Operand forwarding muxes
  always_comb begin
    case (E_FwdRS)
      FWD_DE:  a_c = DE_RD1;
      FWD_M:   a_c = E_M_Pass;
      FWD_W:   a_c = E_W_Pass;
      default: a_c = DE_RD1;
    endcase
    case (E_FwdRT)
      FWD_DE:  b_c = DE_RD2;
      FWD_M:   b_c = E_M_Pass;
      FWD_W:   b_c = E_W_Pass;
      default: b_c = DE_RD2;
    endcase
  end

  // ALU and muldiv decode
  always_comb begin
    alu_c = '0;
`ifdef MULDIV_EN
    md_start_c = 1'b0;
    md_op_c    = MD_NONE;
`endif
    case (instr_op(DE_instruc))
      OP_SPECIAL: begin
        case (instr_funct(DE_instruc))
          FN_ADDU: alu_c = a_c + b_c;
          FN_SUBU: alu_c = a_c - b_c;
          FN_JR:   alu_c = '0;
`ifdef MULDIV_EN
          FN_MULT:  begin md_start_c = 1'b1; md_op_c = MD_MULT;  end
          FN_MULTU: begin md_start_c = 1'b1; md_op_c = MD_MULTU; end
          FN_DIV:   begin md_start_c = 1'b1; md_op_c = MD_DIV;   end
          FN_DIVU:  begin md_start_c = 1'b1; md_op_c = MD_DIVU;  end
          FN_MTHI:  md_op_c = MD_MTHI;
          FN_MTLO:  md_op_c = MD_MTLO;
          FN_MFHI:  alu_c = md_hi;
          FN_MFLO:  alu_c = md_lo;
`else
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
          FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO: alu_c = '0;
`endif
          default: alu_c = '0;
        endcase
      end
      OP_ORI:        alu_c = a_c | DE_Ext;
      OP_LUI:        alu_c = {DE_Ext[15:0], 16'h0000};
      OP_LW, OP_SW:  alu_c = a_c + DE_Ext;
      OP_JAL:        alu_c = DE_PC + XLEN'(8);
      OP_BEQ:        alu_c = '0;
      default:       alu_c = '0;
    endcase
  end

  // Assemble the E->M payload
  always_comb begin
    em_d         = '0;
    em_d.alu_out = alu_c;
    em_d.rd2     = b_c;
    em_d.instruc = DE_instruc;
    em_d.pc      = DE_PC;
    em_d.wra     = DE_WRA;
  end

  // E->M pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      em_q <= '0;
    end else begin
      em_q <= em_d;
    end
  end

  assign EM_ALUOut  = em_q.alu_out;
  assign EM_RD2     = em_q.rd2;
  assign EM_instruc = em_q.instruc;
  assign EM_PC      = em_q.pc;
  assign EM_WRA     = em_q.wra;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage. Expected EM_* values are queued when an
// instruction is driven and compared one cycle later. Muldiv expectations
// follow MULDIV_EN: with it undefined those ops must behave as nops.
module tb_ex_stage;

`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DE_RD1, DE_RD2, DE_instruc, DE_Ext, DE_PC;
  logic [4:0]  DE_WRA;
  logic [1:0]  E_FwdRS, E_FwdRT;
  logic [31:0] E_M_Pass, E_W_Pass;
  logic [4:0]  E_rs, E_rt;
  logic        E_mdBusy;
  logic [31:0] EM_ALUOut, EM_RD2, EM_instruc, EM_PC;
  logic [4:0]  EM_WRA;

  always #5 clk = ~clk;

  ex_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .DE_RD1(DE_RD1), .DE_RD2(DE_RD2), .DE_instruc(DE_instruc),
    .DE_WRA(DE_WRA), .DE_Ext(DE_Ext), .DE_PC(DE_PC),
    .E_FwdRS(E_FwdRS), .E_FwdRT(E_FwdRT),
    .E_M_Pass(E_M_Pass), .E_W_Pass(E_W_Pass),
    .E_rs(E_rs), .E_rt(E_rt), .E_mdBusy(E_mdBusy),
    .EM_ALUOut(EM_ALUOut), .EM_RD2(EM_RD2), .EM_instruc(EM_instruc),
    .EM_PC(EM_PC), .EM_WRA(EM_WRA)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  wra;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_prev();
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("em_aluout",  EM_ALUOut,  e.alu);
      check("em_rd2",     EM_RD2,     e.rd2);
      check("em_instruc", EM_instruc, e.instr);
      check("em_pc",      EM_PC,      e.pc);
      check("em_wra",     32'(EM_WRA), 32'(e.wra));
    end
  endtask

  task automatic issue(input logic [31:0] instr, input logic [4:0] wra,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] ext, input logic [31:0] pc,
                       input logic [1:0] frs, input logic [1:0] frt,
                       input logic [31:0] exp_alu, input logic [31:0] exp_rd2);
    exp_t e;
    @(negedge clk);
    check_prev();
    DE_instruc = instr;
    DE_WRA     = wra;
    DE_RD1     = rd1;
    DE_RD2     = rd2;
    DE_Ext     = ext;
    DE_PC      = pc;
    E_FwdRS    = frs;
    E_FwdRT    = frt;
    e.alu   = exp_alu;
    e.rd2   = exp_rd2;
    e.instr = instr;
    e.pc    = pc;
    e.wra   = wra;
    sb_q.push_back(e);
    #1 last_busy = E_mdBusy;
  endtask

  task automatic nop();
    issue(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  // Counts consecutive busy cycles starting with the one just issued
  task automatic count_busy(output int n);
    n = 0;
    while (last_busy && n < 50) begin
      n++;
      nop();
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    DE_RD1 = '0; DE_RD2 = '0; DE_instruc = '0; DE_WRA = '0; DE_Ext = '0; DE_PC = '0;
    E_FwdRS = '0; E_FwdRT = '0; E_M_Pass = '0; E_W_Pass = '0;
    repeat (2) @(negedge clk);
    check("rst_aluout",  EM_ALUOut,  32'h0);
    check("rst_rd2",     EM_RD2,     32'h0);
    check("rst_instruc", EM_instruc, 32'h0);
    check("rst_pc",      EM_PC,      32'h0);
    check("rst_wra",     32'(EM_WRA), 32'h0);
    check("rst_busy",    32'(E_mdBusy), 32'h0);
    reset = 1'b0;

    // ALU, forwarding, pass-through
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h21), 5'd3, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h1000,
          2'b00, 2'b00, 32'h1, 32'h2);
    check("e_rs", 32'(E_rs), 32'd1);
    check("e_rt", 32'(E_rt), 32'd2);
    issue(rtype(5'd4, 5'd5, 5'd6, 6'h23), 5'd6, 32'h5, 32'h7, 32'h0, 32'h1004,
          2'b00, 2'b00, 32'hFFFF_FFFE, 32'h7);
    E_M_Pass = 32'h10;
    issue(itype(6'h0D, 5'd7, 5'd8, 16'h000F), 5'd8, 32'hDEAD_0000, 32'h55, 32'hF, 32'h1008,
          2'b01, 2'b00, 32'h1F, 32'h55);
    E_W_Pass = 32'hCAFE_BABE;
    issue(itype(6'h2B, 5'd9, 5'd10, 16'h0008), 5'd0, 32'h100, 32'h77, 32'h8, 32'h100C,
          2'b00, 2'b10, 32'h108, 32'hCAFE_BABE);
    issue(itype(6'h0F, 5'd0, 5'd11, 16'hABCD), 5'd11, 32'h999, 32'h0, 32'h0000_ABCD, 32'h1010,
          2'b00, 2'b00, 32'hABCD_0000, 32'h0);
    issue(itype(6'h23, 5'd12, 5'd13, 16'hFFFC), 5'd13, 32'h200, 32'h3, 32'hFFFF_FFFC, 32'h1014,
          2'b11, 2'b11, 32'h1FC, 32'h3);
    issue({6'h03, 26'h0000C00}, 5'd31, 32'h0, 32'h0, 32'h0, 32'h3000,
          2'b00, 2'b00, 32'h3008, 32'h0);
    issue(itype(6'h04, 5'd1, 5'd2, 16'h0010), 5'd0, 32'h5, 32'h5, 32'h10, 32'h3004,
          2'b00, 2'b00, 32'h0, 32'h5);

    // Signed multiply -3 * 7
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h18), 5'd0, 32'hFFFF_FFFD, 32'h7, 32'h0, 32'h2000,
          2'b00, 2'b00, 32'h0, 32'h7);
    count_busy(n);
    check("mult_busy_cycles", 32'(n), MD ? 32'd6 : 32'd0);
    issue(rtype(5'd0, 5'd0, 5'd4, 6'h10), 5'd4, 32'h0, 32'h0, 32'h0, 32'h2004,
          2'b00, 2'b00, MD ? 32'hFFFF_FFFF : 32'h0, 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd5, 6'h12), 5'd5, 32'h0, 32'h0, 32'h0, 32'h2008,
          2'b00, 2'b00, MD ? 32'hFFFF_FFEB : 32'h0, 32'h0);

    // Signed divide -7 / 2
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h1A), 5'd0, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h2010,
          2'b00, 2'b00, 32'h0, 32'h2);
    count_busy(n);
    check("div_busy_cycles", 32'(n), MD ? 32'd11 : 32'd0);
    issue(rtype(5'd0, 5'd0, 5'd5, 6'h12), 5'd5, 32'h0, 32'h0, 32'h0, 32'h2014,
          2'b00, 2'b00, MD ? 32'hFFFF_FFFD : 32'h0, 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd4, 6'h10), 5'd4, 32'h0, 32'h0, 32'h0, 32'h2018,
          2'b00, 2'b00, MD ? 32'hFFFF_FFFF : 32'h0, 32'h0);

    // mthi/mtlo visible on the next cycle, no busy
    issue(rtype(5'd6, 5'd0, 5'd0, 6'h11), 5'd0, 32'h1111_1111, 32'h0, 32'h0, 32'h2020,
          2'b00, 2'b00, 32'h0, 32'h0);
    check("mthi_busy", 32'(last_busy), 32'h0);
    issue(rtype(5'd6, 5'd0, 5'd0, 6'h13), 5'd0, 32'h2222_2222, 32'h0, 32'h0, 32'h2024,
          2'b00, 2'b00, 32'h0, 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd4, 6'h10), 5'd4, 32'h0, 32'h0, 32'h0, 32'h2028,
          2'b00, 2'b00, MD ? 32'h1111_1111 : 32'h0, 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd5, 6'h12), 5'd5, 32'h0, 32'h0, 32'h0, 32'h202C,
          2'b00, 2'b00, MD ? 32'h2222_2222 : 32'h0, 32'h0);

    // Unsigned divide by zero leaves HI/LO alone but still runs full length
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h1B), 5'd0, 32'h5, 32'h0, 32'h0, 32'h2030,
          2'b00, 2'b00, 32'h0, 32'h0);
    count_busy(n);
    check("divu0_busy_cycles", 32'(n), MD ? 32'd11 : 32'd0);
    issue(rtype(5'd0, 5'd0, 5'd4, 6'h10), 5'd4, 32'h0, 32'h0, 32'h0, 32'h2034,
          2'b00, 2'b00, MD ? 32'h1111_1111 : 32'h0, 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd5, 6'h12), 5'd5, 32'h0, 32'h0, 32'h0, 32'h2038,
          2'b00, 2'b00, MD ? 32'h2222_2222 : 32'h0, 32'h0);

    // multu with an mtlo arriving while busy (must be dropped)
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h19), 5'd0, 32'h0001_0001, 32'h0001_0000, 32'h0, 32'h2040,
          2'b00, 2'b00, 32'h0, 32'h0001_0000);
    issue(rtype(5'd6, 5'd0, 5'd0, 6'h13), 5'd0, 32'h1234, 32'h0, 32'h0, 32'h2044,
          2'b00, 2'b00, 32'h0, 32'h0);
    check("busy_during_mtlo", 32'(last_busy), 32'(MD));
    count_busy(n);
    issue(rtype(5'd0, 5'd0, 5'd4, 6'h10), 5'd4, 32'h0, 32'h0, 32'h0, 32'h2048,
          2'b00, 2'b00, MD ? 32'h1 : 32'h0, 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd5, 6'h12), 5'd5, 32'h0, 32'h0, 32'h0, 32'h204C,
          2'b00, 2'b00, MD ? 32'h0001_0000 : 32'h0, 32'h0);

    // Reset during busy cycle 3 of a divide
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h1A), 5'd0, 32'd100, 32'd7, 32'h0, 32'h2050,
          2'b00, 2'b00, 32'h0, 32'd7);
    nop();
    nop();
    @(negedge clk);
    check_prev();
    reset      = 1'b1;
    DE_instruc = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    DE_WRA     = 5'd3;
    DE_RD1     = 32'h1;
    DE_RD2     = 32'h1;
    DE_PC      = 32'h40;
    @(negedge clk);
    reset = 1'b0;
    DE_instruc = '0; DE_WRA = '0; DE_RD1 = '0; DE_RD2 = '0; DE_PC = '0;
    sb_q.delete();
    #1;
    check("rst2_aluout",  EM_ALUOut,  32'h0);
    check("rst2_rd2",     EM_RD2,     32'h0);
    check("rst2_instruc", EM_instruc, 32'h0);
    check("rst2_pc",      EM_PC,      32'h0);
    check("rst2_wra",     32'(EM_WRA), 32'h0);
    check("rst2_busy",    32'(E_mdBusy), 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd4, 6'h10), 5'd4, 32'h0, 32'h0, 32'h0, 32'h2060,
          2'b00, 2'b00, 32'h0, 32'h0);
    issue(rtype(5'd0, 5'd0, 5'd5, 6'h12), 5'd5, 32'h0, 32'h0, 32'h0, 32'h2064,
          2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check_prev();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
